dmem_access_ctrl: RTL and testbench

//  Sequencer and arbiter in front of the byte-addressed data memory of the multi-cycle RV32I core.
//  - Shares the memory between two requesters: the core (CPU port) and a debug/loader (DBG port).
//  - Issues exactly one single-cycle access strobe per transaction.
//  - Handles RV32I load/store sizing: byte enables, lane steering, sign/zero extension.
//  - Faults misaligned, illegal and out-of-range accesses without touching memory.

---
 rtl/dmem_pkg.sv | 27 ++
 rtl/dmem_load_align.sv | 41 ++++
 rtl/dmem_access_ctrl.sv | 279 +++++++++++++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory access sequencer.
// Included by the top and the load aligner.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_RESP  = 3'd3;
  localparam logic [2:0] ST_FAULT = 3'd4;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/dmem_load_align.sv
// Picks the addressed lane out of a raw little-endian memory word and
// sign- or zero-extends it according to the RV32I load funct3.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection followed by extension.
  always_comb begin
    case (lane_i)
      2'b00:   byte_s = rdata_i[7:0];
      2'b01:   byte_s = rdata_i[15:8];
      2'b10:   byte_s = rdata_i[23:16];
      2'b11:   byte_s = rdata_i[31:24];
      default: byte_s = 8'h00;
    endcase

    if (lane_i[1]) begin
      half_s = rdata_i[31:16];
    end else begin
      half_s = rdata_i[15:0];
    end

    case (funct3_i)
      F3_B:    data_o = {{24{byte_s[7]}}, byte_s};
      F3_BU:   data_o = {24'h000000, byte_s};
      F3_H:    data_o = {{16{half_s[15]}}, half_s};
      F3_HU:   data_o = {16'h0000, half_s};
      F3_W:    data_o = rdata_i;
      default: data_o = 32'h00000000;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Arbitrates CPU and debug access to the data memory, issues one strobe per
// transaction, sizes/steers stores and aligns/extends loads.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int MEM_LAT = 1
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [2:0]        cpu_funct3_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic              cpu_done_o,
  output logic [31:0]       cpu_rdata_o,
  output logic              cpu_fault_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [31:0]       dbg_addr_i,
  input  logic [31:0]       dbg_wdata_i,
  output logic              dbg_done_o,
  output logic [31:0]       dbg_rdata_o,
  output logic              dbg_fault_o,
  output logic              mem_en_o,
  output logic              mem_load_o,
  output logic              mem_store_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  logic [2:0]        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        lane_q, lane_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_load_q, mem_load_d;
  logic              mem_store_q, mem_store_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              cpu_done_q, cpu_done_d;
  logic              cpu_fault_q, cpu_fault_d;
  logic [31:0]       cpu_rdata_q, cpu_rdata_d;
  logic              dbg_done_q, dbg_done_d;
  logic              dbg_fault_q, dbg_fault_d;
  logic [31:0]       dbg_rdata_q, dbg_rdata_d;

  mem_req_t    req_s;
  logic        any_req_s;
  logic        sel_dbg_s;
  logic        legal_s;
  logic        misal_s;
  logic        range_s;
  logic        fault_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s;
  logic [31:0] ld_data_s;

  // Round-robin: on a tie DBG wins only if CPU held the last grant.
  always_comb begin
    any_req_s = cpu_req_i | dbg_req_i;
    sel_dbg_s = dbg_req_i & (~cpu_req_i | (last_grant_q == OWN_CPU));
    if (sel_dbg_s) begin
      req_s.we    = dbg_we_i;
      req_s.f3    = F3_W;
      req_s.addr  = dbg_addr_i;
      req_s.wdata = dbg_wdata_i;
    end else begin
      req_s.we    = cpu_we_i;
      req_s.f3    = cpu_funct3_i;
      req_s.addr  = cpu_addr_i;
      req_s.wdata = cpu_wdata_i;
    end
  end

  // Legality of the selected request; unsigned variants exist only for loads.
  always_comb begin
    case (req_s.f3)
      F3_B: begin
        legal_s = 1'b1;
        misal_s = 1'b0;
      end
      F3_H: begin
        legal_s = 1'b1;
        misal_s = req_s.addr[0];
      end
      F3_W: begin
        legal_s = 1'b1;
        misal_s = |req_s.addr[1:0];
      end
      F3_BU: begin
        legal_s = ~req_s.we;
        misal_s = 1'b0;
      end
      F3_HU: begin
        legal_s = ~req_s.we;
        misal_s = req_s.addr[0];
      end
      default: begin
        legal_s = 1'b0;
        misal_s = 1'b0;
      end
    endcase
    range_s = |req_s.addr[31:ADDR_W];
    fault_s = ~legal_s | misal_s | range_s;
  end

  // Store lane steering: narrow data is replicated so every lane carries it.
  always_comb begin
    if (req_s.we) begin
      case (req_s.f3)
        F3_B: begin
          be_s    = 4'b0001 << req_s.addr[1:0];
          wdata_s = {4{req_s.wdata[7:0]}};
        end
        F3_H: begin
          be_s    = 4'b0011 << req_s.addr[1:0];
          wdata_s = {2{req_s.wdata[15:0]}};
        end
        default: begin
          be_s    = 4'b1111;
          wdata_s = req_s.wdata;
        end
      endcase
    end else begin
      be_s    = 4'b0000;
      wdata_s = 32'h00000000;
    end
  end

  dmem_load_align u_load_align (
    .rdata_i  (mem_rdata_i),
    .lane_i   (lane_q),
    .funct3_i (f3_q),
    .data_o   (ld_data_s)
  );

  // Sequencer next state; strobes and done pulses default low every cycle.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    we_d         = we_q;
    f3_d         = f3_q;
    lane_d       = lane_q;
    cnt_d        = cnt_q;
    mem_en_d     = 1'b0;
    mem_load_d   = 1'b0;
    mem_store_d  = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_done_d   = 1'b0;
    cpu_fault_d  = 1'b0;
    cpu_rdata_d  = 32'h00000000;
    dbg_done_d   = 1'b0;
    dbg_fault_d  = 1'b0;
    dbg_rdata_d  = 32'h00000000;

    case (state_q)
      ST_IDLE: begin
        if (any_req_s) begin
          last_grant_d = sel_dbg_s;
          owner_d      = sel_dbg_s;
          we_d         = req_s.we;
          f3_d         = req_s.f3;
          lane_d       = req_s.addr[1:0];
          if (fault_s) begin
            state_d = ST_FAULT;
            if (sel_dbg_s) begin
              dbg_done_d  = 1'b1;
              dbg_fault_d = 1'b1;
            end else begin
              cpu_done_d  = 1'b1;
              cpu_fault_d = 1'b1;
            end
          end else begin
            state_d     = ST_ISSUE;
            mem_en_d    = 1'b1;
            mem_load_d  = ~req_s.we;
            mem_store_d = req_s.we;
            mem_addr_d  = {req_s.addr[ADDR_W-1:2], 2'b00};
            mem_be_d    = be_s;
            mem_wdata_d = wdata_s;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = 3'(MEM_LAT - 1);
      end
      ST_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_RESP;
          if (owner_q == OWN_DBG) begin
            dbg_done_d  = 1'b1;
            dbg_rdata_d = we_q ? 32'h00000000 : ld_data_s;
          end else begin
            cpu_done_d  = 1'b1;
            cpu_rdata_d = we_q ? 32'h00000000 : ld_data_s;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_RESP:  state_d = ST_IDLE;
      ST_FAULT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q      <= ST_IDLE;
      last_grant_q <= OWN_DBG;
      owner_q      <= OWN_CPU;
      we_q         <= 1'b0;
      f3_q         <= 3'b000;
      lane_q       <= 2'b00;
      cnt_q        <= 3'd0;
      mem_en_q     <= 1'b0;
      mem_load_q   <= 1'b0;
      mem_store_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= 4'b0000;
      mem_wdata_q  <= 32'h00000000;
      cpu_done_q   <= 1'b0;
      cpu_fault_q  <= 1'b0;
      cpu_rdata_q  <= 32'h00000000;
      dbg_done_q   <= 1'b0;
      dbg_fault_q  <= 1'b0;
      dbg_rdata_q  <= 32'h00000000;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      f3_q         <= f3_d;
      lane_q       <= lane_d;
      cnt_q        <= cnt_d;
      mem_en_q     <= mem_en_d;
      mem_load_q   <= mem_load_d;
      mem_store_q  <= mem_store_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_done_q   <= cpu_done_d;
      cpu_fault_q  <= cpu_fault_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_done_q   <= dbg_done_d;
      dbg_fault_q  <= dbg_fault_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  assign cpu_done_o  = cpu_done_q;
  assign cpu_fault_o = cpu_fault_q;
  assign cpu_rdata_o = cpu_rdata_q;
  assign dbg_done_o  = dbg_done_q;
  assign dbg_fault_o = dbg_fault_q;
  assign dbg_rdata_o = dbg_rdata_q;
  assign mem_en_o    = mem_en_q;
  assign mem_load_o  = mem_load_q;
  assign mem_store_o = mem_store_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_be_o    = mem_be_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Randomized self-checking bench for dmem_access_ctrl with a byte-array
// reference model of memory, arbitration and RV32I load/store semantics.
module tb_dmem_access_ctrl;

  localparam int AW  = 5;
  localparam int LAT = 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cpu_req, cpu_we, dbg_req, dbg_we;
  logic [2:0]    cpu_funct3;
  logic [31:0]   cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic          cpu_done, cpu_fault, dbg_done, dbg_fault;
  logic [31:0]   cpu_rdata, dbg_rdata;
  logic          mem_en, mem_load, mem_store;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata, mem_rdata;

  dmem_access_ctrl #(.ADDR_W(AW), .MEM_LAT(LAT)) dut (
    .clk_i(clk), .reset_ni(reset_n),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_funct3_i(cpu_funct3),
    .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_done_o(cpu_done), .cpu_rdata_o(cpu_rdata), .cpu_fault_o(cpu_fault),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
    .dbg_done_o(dbg_done), .dbg_rdata_o(dbg_rdata), .dbg_fault_o(dbg_fault),
    .mem_en_o(mem_en), .mem_load_o(mem_load), .mem_store_o(mem_store),
    .mem_addr_o(mem_addr), .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          strobe_cnt = 0;
  logic        mem_init;
  logic [7:0]  phys [32];
  logic [7:0]  ref_mem [32];
  logic [31:0] rd_pipe [LAT];
  logic        rd_vld [LAT];
  logic [31:0] junk;
  bit          rr_last_dbg;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory device: byte writes on store strobes, read data LAT cycles after strobe.
  always @(posedge clk) begin
    junk <= $urandom;
    if (mem_init) begin
      for (int i = 0; i < 32; i++) phys[i] <= 8'(i * 37 + 11);
    end else if (mem_en && mem_store) begin
      for (int i = 0; i < 4; i++)
        if (mem_be[i]) phys[int'(mem_addr) + i] <= mem_wdata[8*i +: 8];
    end
    rd_vld[0]  <= mem_en && mem_load;
    rd_pipe[0] <= {phys[int'(mem_addr) + 3], phys[int'(mem_addr) + 2],
                   phys[int'(mem_addr) + 1], phys[int'(mem_addr)]};
    for (int i = 1; i < LAT; i++) begin
      rd_vld[i]  <= rd_vld[i-1];
      rd_pipe[i] <= rd_pipe[i-1];
    end
  end
  assign mem_rdata = rd_vld[LAT-1] ? rd_pipe[LAT-1] : junk;

  always @(negedge clk) begin
    if (mem_en) strobe_cnt <= strobe_cnt + 1;
    if (cpu_done || dbg_done) check_val("one_done", 32'(cpu_done & dbg_done), 32'd0);
  end

  // Access size in bytes, 0 when the funct3/direction pair is illegal.
  function automatic int ref_size(input logic we, input logic [2:0] f3);
    case (f3)
      3'b000:  return 1;
      3'b001:  return 2;
      3'b010:  return 4;
      3'b100:  return we ? 0 : 1;
      3'b101:  return we ? 0 : 2;
      default: return 0;
    endcase
  endfunction

  function automatic bit ref_fault(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int sz = ref_size(we, f3);
    if (sz == 0) return 1'b1;
    if (a > 32'd31) return 1'b1;
    return (a % 32'(sz)) != 32'd0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    int sz = ref_size(1'b0, f3);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < sz; i++) v = v | (32'(ref_mem[int'(a) + i]) << (8 * i));
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8 * sz)) - 32'd1);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    cpu_req = 1'b1; cpu_we = we; cpu_funct3 = f3; cpu_addr = a; cpu_wdata = wd;
  endtask

  task automatic set_dbg(input logic we, input logic [31:0] a, input logic [31:0] wd);
    dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = wd;
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return $urandom;
    return 32'($urandom_range(0, 31));
  endfunction

  task automatic rand_cpu();
    set_cpu(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rand_addr(), $urandom);
  endtask

  task automatic rand_dbg();
    set_dbg(1'($urandom_range(0, 1)), rand_addr() & 32'hFFFF_FFFD, $urandom);
  endtask

  // One transaction from the IDLE sampling cycle through its done pulse.
  task automatic run_txn(output bit won_dbg);
    bit w, flt, done_seen;
    logic we;
    logic [2:0] f3;
    logic [31:0] a, wd, exp_rd, exp_wd;
    logic [3:0] exp_be;
    int sz, lat, cyc, s0;
    w = dbg_req && (!cpu_req || !rr_last_dbg);
    if (w) begin we = dbg_we; f3 = 3'b010; a = dbg_addr; wd = dbg_wdata; end
    else   begin we = cpu_we; f3 = cpu_funct3; a = cpu_addr; wd = cpu_wdata; end
    sz     = ref_size(we, f3);
    flt    = ref_fault(we, f3, a);
    lat    = flt ? 1 : 2 + LAT;
    exp_rd = (flt || we) ? 32'd0 : ref_load(f3, a);
    exp_be = (we && !flt) ? 4'(((1 << sz) - 1) << int'(a[1:0])) : 4'b0000;
    exp_wd = (sz == 1) ? {24'd0, wd[7:0]} * 32'h01010101 :
             (sz == 2) ? {16'd0, wd[15:0]} * 32'h00010001 : wd;
    s0 = strobe_cnt;
    cyc = 0;
    done_seen = 1'b0;
    while (!done_seen && cyc < 40) begin
      step();
      cyc++;
      if (cyc == 1 && !flt) begin
        check_val("mem_en", 32'(mem_en), 32'd1);
        check_val("mem_load", 32'(mem_load), 32'(!we));
        check_val("mem_store", 32'(mem_store), 32'(we));
        check_val("mem_addr", 32'(mem_addr), {27'd0, a[4:2], 2'b00});
        check_val("mem_be", 32'(mem_be), 32'(exp_be));
        if (we) check_val("mem_wdata", mem_wdata, exp_wd);
      end
      done_seen = cpu_done || dbg_done;
    end
    won_dbg = w;
    if (!done_seen) begin
      check_val("done_timeout", 32'd0, 32'd1);
      return;
    end
    check_val("grant_dbg", 32'(dbg_done), 32'(w));
    check_val("grant_cpu", 32'(cpu_done), 32'(!w));
    check_val("latency", 32'(cyc), 32'(lat));
    check_val("fault", 32'(w ? dbg_fault : cpu_fault), 32'(flt));
    check_val("rdata", w ? dbg_rdata : cpu_rdata, exp_rd);
    check_val("strobes", 32'(strobe_cnt - s0), flt ? 32'd0 : 32'd1);
    if (!flt && we)
      for (int i = 0; i < sz; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
    rr_last_dbg = w;
  endtask

  task automatic serve_all();
    bit w;
    while (cpu_req || dbg_req) begin
      run_txn(w);
      if (w) dbg_req = 1'b0;
      else   cpu_req = 1'b0;
      step();
    end
  endtask

  initial begin
    bit w, seen;
    logic [3:0] grants;
    reset_n = 1'b0; mem_init = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_funct3 = 3'b000; cpu_addr = 32'd0; cpu_wdata = 32'd0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 32'd0; dbg_wdata = 32'd0;
    for (int i = 0; i < 32; i++) ref_mem[i] = 8'(i * 37 + 11);
    rr_last_dbg = 1'b1;
    repeat (3) step();
    check_val("reset_outs", 32'(|{cpu_done, cpu_fault, cpu_rdata, dbg_done, dbg_fault, dbg_rdata,
                                  mem_en, mem_load, mem_store, mem_addr, mem_be, mem_wdata}), 32'd0);
    reset_n = 1'b1; mem_init = 1'b0;
    step();

    // Both requesters held: CPU first after reset, then alternation.
    set_cpu(1'b1, 3'b010, 32'h10, 32'h11223344);
    set_dbg(1'b0, 32'h14, 32'h0);
    grants = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      run_txn(w);
      grants[i] = w;
      if (i < 3) begin
        if (w) rand_dbg(); else rand_cpu();
      end else begin
        if (w) dbg_req = 1'b0; else cpu_req = 1'b0;
      end
      step();
    end
    serve_all();
    check_val("rr_order", 32'(grants), 32'b1010);

    set_cpu(1'b1, 3'b010, 32'h08, 32'hDEADBEEF); serve_all();
    set_cpu(1'b0, 3'b000, 32'h09, 32'h0); serve_all();
    set_cpu(1'b0, 3'b100, 32'h0B, 32'h0); serve_all();
    set_cpu(1'b0, 3'b001, 32'h0A, 32'h0); serve_all();
    set_cpu(1'b0, 3'b101, 32'h08, 32'h0); serve_all();
    set_cpu(1'b1, 3'b001, 32'h0E, 32'h00001234); serve_all();
    set_cpu(1'b0, 3'b010, 32'h06, 32'h0); serve_all();
    set_cpu(1'b1, 3'b001, 32'h03, 32'h0); serve_all();
    set_cpu(1'b0, 3'b011, 32'h00, 32'h0); serve_all();
    set_cpu(1'b0, 3'b000, 32'h40, 32'h0); serve_all();
    set_dbg(1'b0, 32'h0E, 32'h0); serve_all();

    // Reset while a CPU load waits on memory.
    set_cpu(1'b0, 3'b010, 32'h08, 32'h0);
    step();
    step();
    reset_n = 1'b0;
    cpu_req = 1'b0;
    step();
    check_val("midrst_outs", 32'(|{cpu_done, cpu_fault, cpu_rdata, dbg_done, dbg_fault, dbg_rdata,
                                   mem_en, mem_load, mem_store, mem_addr, mem_be, mem_wdata}), 32'd0);
    step();
    reset_n = 1'b1;
    rr_last_dbg = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      step();
      if (cpu_done || dbg_done) seen = 1'b1;
    end
    check_val("midrst_no_done", 32'(seen), 32'd0);
    set_cpu(1'b0, 3'b010, 32'h08, 32'h0); serve_all();

    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 2))
        0:       rand_cpu();
        1:       rand_dbg();
        default: begin rand_cpu(); rand_dbg(); end
      endcase
      serve_all();
      repeat ($urandom_range(0, 2)) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
